// File: rtl/aes_masked_o1_dsbox.sv
// aes_masked_o1_dsbox
// First-order Boolean-masked AES-128 encryption core. The datapath is byte-serial
// and uses a single masked S-box (DSbox). Every intermediate value is held as two
// shares, and the true value is share0 ^ share1. Only the DSbox uses fresh
// randomness.
//
// Ports:
//   clk              rising-edge clock
//   rstn             synchronous active-low reset
//   plain0/plain1    plaintext byte shares, FIPS-197 byte order, byte 0 first
//   key0/key1        key byte shares, captured alongside the plaintext
//   pk_valid         plain*/key* valid this cycle (ignored once loading completes)
//   random           fresh random byte, consumed by the DSbox
//   cipher0/cipher1  ciphertext byte-pair shares {byte 2k, byte 2k+1}
//   done             cipher* valid this cycle (8 consecutive cycles)
//   busy             block occupied
module aes_masked_o1_dsbox (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  plain0,
  input  logic [7:0]  plain1,
  input  logic        pk_valid,
  input  logic [7:0]  key0,
  input  logic [7:0]  key1,
  input  logic [7:0]  random,
  output logic [15:0] cipher0,
  output logic [15:0] cipher1,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, KS, SB, LIN, OUT} state_t;

  state_t       state_reg, state_next;
  logic [3:0]   byte_cnt_reg;
  logic [4:0]   cyc_cnt_reg;
  logic [3:0]   round_reg;
  logic [3:0]   out_cnt_reg;
  logic [7:0]   rcon_reg;
  logic [127:0] st0_reg, st1_reg, k0_reg, k1_reg;  // byte 0 in bits [127:120]
  logic [23:0]  t0_reg, t1_reg;                    // SubWord bytes 0..2 of the key step
  logic [7:0]   sb_a0, sb_a1, sb_b0_reg, sb_b1_reg;
  logic         done_reg;
  logic [15:0]  cipher0_reg, cipher1_reg;

  // GF(2^8) helpers over the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] a);
    return gf_mul(a, a);
  endfunction

  // DOM-style masked multiply. The cross terms are refreshed with r before they
  // are folded into a share, so the two input shares never meet unmasked.
  function automatic logic [15:0] dom_mul(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] r);
    return {gf_mul(a0, b0) ^ (gf_mul(a0, b1) ^ r), gf_mul(a1, b1) ^ (gf_mul(a1, b0) ^ r)};
  endfunction

  // Linear part of the S-box affine map. The 0x63 constant goes on share 0 only.
  function automatic logic [7:0] aff_lin(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
  endfunction

  // Bit offset of byte i in a 128-bit state (byte 0 is the most significant)
  function automatic logic [6:0] bp(input logic [3:0] i);
    return {~i, 3'b000};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Key expansion on one share. sw is SubWord(RotWord(w3)), with Rcon already
  // folded in on share 0.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [31:0] sw);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sw;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pk_valid) state_next = LOAD;
      LOAD:    if (pk_valid && byte_cnt_reg == 4'd15) state_next = KS;
      KS:      if (cyc_cnt_reg == 5'd4) state_next = SB;
      SB:      if (cyc_cnt_reg == 5'd16) state_next = LIN;
      LIN:     state_next = (round_reg == 4'd10) ? OUT : KS;
      OUT:     if (out_cnt_reg == 4'd8) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- DSbox ----------------
  // KS feeds RotWord(w3): cycle j reads key byte 12 + ((j+1) mod 4).
  // SB feeds state byte j.
  always_comb begin
    sb_a0 = 8'h00;
    sb_a1 = 8'h00;
    if (state_reg == KS) begin
      sb_a0 = k0_reg[bp({2'b11, cyc_cnt_reg[1:0] + 2'd1}) +: 8];
      sb_a1 = k1_reg[bp({2'b11, cyc_cnt_reg[1:0] + 2'd1}) +: 8];
    end else if (state_reg == SB) begin
      sb_a0 = st0_reg[bp(cyc_cnt_reg[3:0]) +: 8];
      sb_a1 = st1_reg[bp(cyc_cnt_reg[3:0]) +: 8];
    end
  end

  // The inversion goes through the GF(2^4) subfield.
  //   The norm a^17 = a * a^16 lies in GF(2^4), and its inverse there is N^14.
  //   Then a^-1 = a^16 * N^-1.
  // The Frobenius powers (squarings) are linear, so they are applied share by
  // share. The four products are DOM gadgets, each refreshed with a different
  // permutation of the random byte.
  logic [7:0]  f0, f1, n2_0, n2_1, n4_0, n4_1, n8_0, n8_1;
  logic [15:0] n_sh, n6_sh, n14_sh, inv_sh;

  assign f0     = gf_sq(gf_sq(gf_sq(gf_sq(sb_a0))));
  assign f1     = gf_sq(gf_sq(gf_sq(gf_sq(sb_a1))));
  assign n_sh   = dom_mul(sb_a0, sb_a1, f0, f1, random);
  assign n2_0   = gf_sq(n_sh[15:8]);
  assign n2_1   = gf_sq(n_sh[7:0]);
  assign n4_0   = gf_sq(n2_0);
  assign n4_1   = gf_sq(n2_1);
  assign n8_0   = gf_sq(n4_0);
  assign n8_1   = gf_sq(n4_1);
  assign n6_sh  = dom_mul(n2_0, n2_1, n4_0, n4_1, {random[3:0], random[7:4]});
  assign n14_sh = dom_mul(n6_sh[15:8], n6_sh[7:0], n8_0, n8_1, ~random);
  assign inv_sh = dom_mul(f0, f1, n14_sh[15:8], n14_sh[7:0], {random[0], random[7:1]});

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sb_b0_reg <= 8'h00;
      sb_b1_reg <= 8'h00;
    end else begin
      sb_b0_reg <= aff_lin(inv_sh[15:8]) ^ 8'h63;
      sb_b1_reg <= aff_lin(inv_sh[7:0]);
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt_reg <= 4'd0;
      cyc_cnt_reg  <= 5'd0;
      round_reg    <= 4'd0;
      out_cnt_reg  <= 4'd0;
      rcon_reg     <= 8'h00;
      st0_reg      <= '0;
      st1_reg      <= '0;
      k0_reg       <= '0;
      k1_reg       <= '0;
      t0_reg       <= '0;
      t1_reg       <= '0;
      done_reg     <= 1'b0;
      cipher0_reg  <= 16'h0;
      cipher1_reg  <= 16'h0;
    end else begin
      cyc_cnt_reg <= (state_next != state_reg) ? 5'd0 : cyc_cnt_reg + 5'd1;
      done_reg    <= 1'b0;
      cipher0_reg <= 16'h0;
      cipher1_reg <= 16'h0;
      case (state_reg)
        IDLE, LOAD: begin
          // byte_cnt_reg wraps 15 -> 0, so it is already cleared for the next block
          if (pk_valid) begin
            st0_reg[bp(byte_cnt_reg) +: 8] <= plain0 ^ key0;
            st1_reg[bp(byte_cnt_reg) +: 8] <= plain1 ^ key1;
            k0_reg[bp(byte_cnt_reg) +: 8]  <= key0;
            k1_reg[bp(byte_cnt_reg) +: 8]  <= key1;
            byte_cnt_reg <= byte_cnt_reg + 4'd1;
            round_reg    <= 4'd1;
            rcon_reg     <= 8'h01;
          end
        end
        KS: begin
          if (cyc_cnt_reg != 5'd0 && cyc_cnt_reg != 5'd4) begin
            t0_reg <= {t0_reg[15:0], sb_b0_reg};
            t1_reg <= {t1_reg[15:0], sb_b1_reg};
          end
          // The fourth SubWord byte is still sitting in the DSbox output register
          if (cyc_cnt_reg == 5'd4) begin
            k0_reg   <= next_key(k0_reg, {t0_reg[23:16] ^ rcon_reg, t0_reg[15:0], sb_b0_reg});
            k1_reg   <= next_key(k1_reg, {t1_reg, sb_b1_reg});
            rcon_reg <= xtime(rcon_reg);
          end
        end
        SB: begin
          // One-cycle DSbox latency: write back the byte issued last cycle
          if (cyc_cnt_reg != 5'd0) begin
            st0_reg[bp(cyc_cnt_reg[3:0] - 4'd1) +: 8] <= sb_b0_reg;
            st1_reg[bp(cyc_cnt_reg[3:0] - 4'd1) +: 8] <= sb_b1_reg;
          end
        end
        LIN: begin
          if (round_reg == 4'd10) begin
            st0_reg <= shift_rows(st0_reg) ^ k0_reg;
            st1_reg <= shift_rows(st1_reg) ^ k1_reg;
          end else begin
            st0_reg   <= mix_columns(shift_rows(st0_reg)) ^ k0_reg;
            st1_reg   <= mix_columns(shift_rows(st1_reg)) ^ k1_reg;
            round_reg <= round_reg + 4'd1;
          end
        end
        OUT: begin
          if (out_cnt_reg != 4'd8) begin
            done_reg    <= 1'b1;
            cipher0_reg <= st0_reg[{~out_cnt_reg[2:0], 4'b0000} +: 16];
            cipher1_reg <= st1_reg[{~out_cnt_reg[2:0], 4'b0000} +: 16];
            out_cnt_reg <= out_cnt_reg + 4'd1;
          end else begin
            out_cnt_reg <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = done_reg;
  assign busy    = (state_reg != IDLE);
  assign cipher0 = cipher0_reg;
  assign cipher1 = cipher1_reg;

endmodule

// File: tb/tb_aes_masked_o1_dsbox.sv
// tb_aes_masked_o1_dsbox
// Self-checking bench for the masked AES-128 core. The recombined ciphertext is
// compared against FIPS-197 constants and against a plain AES-128 reference
// model kept inside this bench.
module tb_aes_masked_o1_dsbox;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pk_valid = 1'b0;
  logic [7:0]  plain0 = 8'h00, plain1 = 8'h00, key0 = 8'h00, key1 = 8'h00, random = 8'h00;
  logic [15:0] cipher0, cipher1;
  logic        done, busy;

  int   total = 0;
  int   bad = 0;
  bit   zero_rand = 1'b0;
  logic [7:0] sbox_tbl [256];

  always #5 clk = ~clk;

  aes_masked_o1_dsbox dut (
    .clk(clk), .rstn(rstn), .plain0(plain0), .plain1(plain1), .pk_valid(pk_valid),
    .key0(key0), .key1(key1), .random(random),
    .cipher0(cipher0), .cipher1(cipher1), .done(done), .busy(busy)
  );

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           gap_at;
    int           gap_len;
    int           extra;
    bit           zero;
    string        name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    random = zero_rand ? 8'h00 : 8'($urandom);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tbl[x] = b;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tbl[tmp[23:16]] ^ rc, sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]], sbox_tbl[tmp[31:24]]};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbox_tbl[s[r][c]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = t[r][(c+r)%4];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
          s[1][c] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
          s[2][c] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
          s[3][c] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(r+4*c) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic vec_t mk(input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] ct, input int gap_at, input int gap_len,
                              input int extra, input bit zero, input string name);
    vec_t v;
    v.pt = pt; v.key = key; v.ct = ct; v.gap_at = gap_at; v.gap_len = gap_len;
    v.extra = extra; v.zero = zero; v.name = name;
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_block(input vec_t v);
    logic [7:0] m, km;
    zero_rand = v.zero;
    if (v.zero) random = 8'h00;
    for (int i = 0; i < 16; i++) begin
      m  = v.zero ? 8'h00 : 8'($urandom);
      km = v.zero ? 8'h00 : 8'($urandom);
      plain0 = v.pt[127-8*i -: 8] ^ m;
      plain1 = m;
      key0 = v.key[127-8*i -: 8] ^ km;
      key1 = km;
      pk_valid = 1'b1;
      step();
      if (i == 0) check($sformatf("%s.busy_up", v.name), {127'd0, busy}, 128'd1);
      if (i == v.gap_at) begin
        pk_valid = 1'b0;
        plain0 = 8'($urandom);
        key0 = 8'($urandom);
        repeat (v.gap_len) step();
      end
    end
  endtask

  task automatic run_block(input vec_t v, output logic [127:0] c0_all);
    logic [127:0] got;
    int n, done_cycles;
    bit lock_ok;
    got = '0;
    c0_all = '0;
    done_cycles = 0;
    lock_ok = 1'b1;
    load_block(v);
    n = 0;
    for (int e = 0; e < v.extra; e++) begin
      plain0 = 8'($urandom); plain1 = 8'($urandom);
      key0 = 8'($urandom); key1 = 8'($urandom);
      pk_valid = 1'b1;
      step();
      n++;
      if (!busy || done) lock_ok = 1'b0;
    end
    if (v.extra > 0) check($sformatf("%s.lockout", v.name), {127'd0, lock_ok}, 128'd1);
    pk_valid = 1'b0;
    plain0 = 8'h00; plain1 = 8'h00; key0 = 8'h00; key1 = 8'h00;
    while (!done && n < 300) begin
      step();
      n++;
    end
    check($sformatf("%s.latency", v.name), 128'(n), 128'd231);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      if (done) done_cycles++;
      got[127-16*k -: 16] = cipher0 ^ cipher1;
      c0_all[127-16*k -: 16] = cipher0;
    end
    check($sformatf("%s.done_cycles", v.name), 128'(done_cycles), 128'd8);
    check($sformatf("%s.ct", v.name), got, v.ct);
    step();
    check($sformatf("%s.idle_after", v.name), {94'd0, done, busy, cipher0, cipher1}, 128'd0);
    $display("block %s: pt=%h key=%h ct=%h latency=%0d", v.name, v.pt, v.key, got, n);
    zero_rand = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [127:0] c0_a, c0_b, c0_dummy;
  int seen_done;

  initial begin
    build_sbox();
    vecs[0] = mk(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, -1, 0, 0, 1'b0, "fips");
    vecs[1] = mk(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, -1, 0, 0, 1'b1, "zero");
    vecs[2] = mk(vecs[0].pt, vecs[0].key, vecs[0].ct, 7, 3, 0, 1'b0, "gapped");
    vecs[3] = mk(vecs[0].pt, vecs[0].key, vecs[0].ct, -1, 0, 24, 1'b0, "lockout");
    for (int i = 4; i < 6; i++) begin
      vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i] = mk(vecs[i].pt, vecs[i].key, aes_ref(vecs[i].pt, vecs[i].key), -1, 0, 0,
                   1'b0, $sformatf("rand%0d", i));
    end

    // reset state
    rstn = 1'b0;
    step();
    step();
    check("reset_state", {94'd0, done, busy, cipher0, cipher1}, 128'd0);
    rstn = 1'b1;
    step();

    // table-driven blocks, back to back
    for (int i = 0; i < 6; i++) run_block(vecs[i], c0_dummy);

    // reset in the middle of processing
    load_block(vecs[0]);
    pk_valid = 1'b0;
    repeat (100) step();
    rstn = 1'b0;
    step();
    check("midreset_outputs", {94'd0, done, busy, cipher0, cipher1}, 128'd0);
    rstn = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 260; i++) begin
      step();
      if (done || busy) seen_done++;
    end
    check("midreset_no_partial", 128'(seen_done), 128'd0);
    $display("midreset: aborted block produced %0d active cycles", seen_done);
    run_block(vecs[0], c0_dummy);

    // two runs of the same block with different masks and random streams
    run_block(vecs[0], c0_a);
    run_block(vecs[0], c0_b);
    check("mask_cipher0_differs", {127'd0, (c0_a != c0_b)}, 128'd1);
    $display("masking: cipher0 run a=%h run b=%h", c0_a, c0_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
